// File: rtl/integration_file_mc.sv
// integration_file_mc: multi-channel Avalon-MM integrator with saturating/wrapping accumulators,
// per-channel write counters, sticky overflow status, bulk clear and a sat/wrap control bit.
module integration_file_mc #(
  parameter int N = 32,
  parameter int CH = 4,
  parameter bit SAT_DEFAULT = 1'b1
) (
  input  logic         csi_clk,
  input  logic         rsi_srst,
  input  logic [7:0]   avs_s0_address,
  input  logic         avs_s0_write,
  input  logic [N-1:0] avs_s0_writedata,
  input  logic         avs_s0_read,
  output logic [N-1:0] avs_s0_readdata
);
  localparam logic [6:0] CHW = 7'(CH);
  logic          w_in_range, w_is_acc, w_is_cnt, w_wr_stat, w_wr_clr, w_wr_ctrl;
  logic [N-1:0]  w_acc [CH];
  logic [N-1:0]  w_cnt [CH];
  logic [CH-1:0] w_status;
  logic [N-1:0]  w_rmux;
  logic          r_sat;
  logic [N-1:0]  r_rdata;
  assign w_in_range = {1'b0, avs_s0_address[5:0]} < CHW;
  assign w_is_acc   = avs_s0_address[7:6] == 2'b00 && w_in_range;
  assign w_is_cnt   = avs_s0_address[7:6] == 2'b10 && w_in_range;
  assign w_wr_stat  = avs_s0_write && avs_s0_address == 8'h40;
  assign w_wr_clr   = avs_s0_write && avs_s0_address == 8'h41;
  assign w_wr_ctrl  = avs_s0_write && avs_s0_address == 8'h42;
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [N-1:0] r_acc, r_cnt;
    logic         r_st, w_wr, w_bit;
    logic [N:0]   w_sum;
    if (c < N) begin : g_b
      assign w_bit = avs_s0_writedata[c];
    end else begin : g_z
      assign w_bit = 1'b0;
    end
    assign w_wr  = avs_s0_write && w_is_acc && avs_s0_address[5:0] == 6'(c);
    assign w_sum = {1'b0, r_acc} + {1'b0, avs_s0_writedata};
    // overflow set is ordered ahead of write-1-to-clear so set wins
    always_ff @(posedge csi_clk) begin
      if (rsi_srst || (w_wr_clr && w_bit)) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_st  <= 1'b0;
      end else begin
        if (w_wr) begin
          r_acc <= (w_sum[N] && r_sat) ? '1 : w_sum[N-1:0];
          r_cnt <= r_cnt + {{(N-1){1'b0}}, ~&r_cnt};
        end
        r_st <= (w_wr && w_sum[N]) || (r_st && !(w_wr_stat && w_bit));
      end
    end
    assign w_acc[c]    = r_acc;
    assign w_cnt[c]    = r_cnt;
    assign w_status[c] = r_st;
  end
  always_comb begin
    w_rmux = '0;
    for (int c = 0; c < CH; c++) begin
      if (w_is_acc && avs_s0_address[5:0] == 6'(c)) w_rmux = w_acc[c];
      if (w_is_cnt && avs_s0_address[5:0] == 6'(c)) w_rmux = w_cnt[c];
    end
    if (avs_s0_address == 8'h40) w_rmux = N'(w_status);
    if (avs_s0_address == 8'h42) w_rmux = N'(r_sat);
  end
  always_ff @(posedge csi_clk) begin
    if (rsi_srst) begin
      r_sat   <= SAT_DEFAULT;
      r_rdata <= '0;
    end else begin
      if (w_wr_ctrl) r_sat <= avs_s0_writedata[0];
      if (avs_s0_read) r_rdata <= w_rmux;
    end
  end
  assign avs_s0_readdata = r_rdata;
endmodule

// File: tb/tb_integration_file_mc.sv
// tb_integration_file_mc: directed register-level checks of integration_file_mc (N=32, CH=4).
module tb_integration_file_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr = '0;
  logic        write = 1'b0, read = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] rdata;
  int n_cmp = 0, n_bad = 0;

  integration_file_mc #(.N(32), .CH(4), .SAT_DEFAULT(1'b1)) dut (
    .csi_clk(clk), .rsi_srst(rst), .avs_s0_address(addr), .avs_s0_write(write),
    .avs_s0_writedata(wd), .avs_s0_read(read), .avs_s0_readdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic op(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    write = w; read = r; addr = a; wd = d;
  endtask

  task automatic idle_chk(input string tag, input logic [31:0] exp);
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    chk(tag, rdata, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    op(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    op(1'b0, 1'b1, a, '0);
    idle_chk(tag, exp);
  endtask

  task automatic rd2(input string tag, input logic [7:0] a0, input logic [31:0] e0,
                     input logic [7:0] a1, input logic [31:0] e1);
    op(1'b0, 1'b1, a0, '0);
    op(1'b0, 1'b1, a1, '0);
    chk({tag, "_a"}, rdata, e0);
    idle_chk({tag, "_b"}, e1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    rd("rst_ctrl", 8'h42, 32'd1);
    rd("rst_status", 8'h40, 32'd0);
    wr(8'h00, 32'd55);
    rd("acc0_55", 8'h00, 32'd55);
    wr(8'h00, 32'd11);
    rd("acc0_66", 8'h00, 32'd66);
    rd("cnt0_2", 8'h80, 32'd2);
    wr(8'h01, 32'hFFFF_FFF0);
    wr(8'h01, 32'h0000_0020);
    rd("acc1_sat", 8'h01, 32'hFFFF_FFFF);
    rd("status_sat", 8'h40, 32'h2);
    wr(8'h40, 32'h2);
    rd("status_w1c", 8'h40, 32'h0);
    wr(8'h42, 32'h0);
    rd("ctrl_wrap", 8'h42, 32'h0);
    wr(8'h41, 32'h2);
    rd("acc1_clr", 8'h01, 32'h0);
    wr(8'h01, 32'hFFFF_FFF0);
    wr(8'h01, 32'h0000_0020);
    rd("acc1_wrap", 8'h01, 32'h10);
    rd("status_wrap", 8'h40, 32'h2);
    wr(8'h42, 32'h1);
    wr(8'h41, 32'hF);
    rd("status_clrall", 8'h40, 32'h0);
    wr(8'h00, 32'd1);
    wr(8'h01, 32'd2);
    wr(8'h02, 32'd3);
    wr(8'h03, 32'd4);
    wr(8'h41, 32'h5);
    rd2("acc01", 8'h00, 32'd0, 8'h01, 32'd2);
    rd2("acc23", 8'h02, 32'd0, 8'h03, 32'd4);
    rd2("cnt01", 8'h80, 32'd0, 8'h81, 32'd1);
    rd2("cnt23", 8'h82, 32'd0, 8'h83, 32'd1);
    rd("clear_reads0", 8'h41, 32'd0);
    wr(8'h02, 32'd4);
    op(1'b1, 1'b1, 8'h02, 32'd7);
    idle_chk("rw_pre", 32'd4);
    rd("rw_post", 8'h02, 32'd11);
    rd("cnt2_2", 8'h82, 32'd2);
    rd("unmapped_rd", 8'h20, 32'd0);
    wr(8'h20, 32'hFF);
    rd("unmapped_wr", 8'h20, 32'd0);
    rd("acc3_keep", 8'h03, 32'd4);
    rd("cnt4_oob", 8'h84, 32'd0);
    wr(8'h03, 32'hFFFF_FFFB);
    rd("acc3_full", 8'h03, 32'hFFFF_FFFF);
    rd("status_noovf", 8'h40, 32'h0);
    wr(8'h03, 32'd1);
    rd("acc3_ovf", 8'h03, 32'hFFFF_FFFF);
    wr(8'h40, 32'hFFFF_FFF0);
    rd("status_hibits", 8'h40, 32'h8);
    wr(8'h41, 32'hF);
    wr(8'h00, 32'd55);
    wr(8'h00, 32'd11);
    rd("acc0_pre_rst", 8'h00, 32'd66);
    wr(8'h42, 32'h0);
    @(negedge clk);
    rst = 1'b1; write = 1'b1; read = 1'b1; addr = 8'h00; wd = 32'd9;
    @(negedge clk);
    chk("rst_mid_rdata", rdata, 32'd0);
    rst = 1'b0; write = 1'b0; read = 1'b0;
    rd("post_rst_acc0", 8'h00, 32'd0);
    rd("post_rst_cnt0", 8'h80, 32'd0);
    rd("post_rst_status", 8'h40, 32'd0);
    rd("post_rst_ctrl", 8'h42, 32'd1);
    wr(8'h00, 32'd5);
    rd("post_rst_acc5", 8'h00, 32'd5);
    repeat (2) @(negedge clk);
    chk("rdata_hold", rdata, 32'd5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
